kws_requant_pack: RTL

KWS_REQUANT_PACK -- requirements
Module: kws_requant_pack

---
 rtl/kws_requant_pkg.sv | 42 ++++
 rtl/kws_round_shift.sv | 24 ++
 rtl/kws_requant_pack.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/kws_requant_pkg.sv
// Shared widths, int8 bounds, reset-time requantization config and config structs
// for the keyword-spotting requantize-and-pack block.
package kws_requant_pkg;

  localparam int ACC_W   = 32;
  localparam int LANES   = 4;
  localparam int OUT_W   = 32;
  localparam int LANE_W  = 8;
  localparam int CNT_W   = 2;
  localparam int SHIFT_W = 5;

  localparam logic signed [LANE_W-1:0] INT8_MIN = 8'sh80;
  localparam logic signed [LANE_W-1:0] INT8_MAX = 8'sh7F;

  localparam logic [ACC_W-1:0] ACC_MIN_BITS = 32'h8000_0000;

  localparam logic signed [ACC_W-1:0]   RST_MULT    = 32'sh4000_0000;
  localparam logic [SHIFT_W-1:0]        RST_SHIFT   = 5'd0;
  localparam logic signed [ACC_W-1:0]   RST_OFFSET  = 32'sd0;
  localparam logic signed [LANE_W-1:0]  RST_ACT_MIN = INT8_MIN;
  localparam logic signed [LANE_W-1:0]  RST_ACT_MAX = INT8_MAX;

  // Offset and clamp bounds travel with each item to stage 3.
  typedef struct packed {
    logic signed [ACC_W-1:0]  offset;
    logic signed [LANE_W-1:0] act_min;
    logic signed [LANE_W-1:0] act_max;
  } clamp_cfg_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] mult;
    logic [SHIFT_W-1:0]      shift;
    clamp_cfg_t              clamp;
  } requant_cfg_t;

  localparam requant_cfg_t RST_CFG = '{
    mult:  RST_MULT,
    shift: RST_SHIFT,
    clamp: '{offset: RST_OFFSET, act_min: RST_ACT_MIN, act_max: RST_ACT_MAX}
  };

endpackage

// File: rtl/kws_round_shift.sv
// Rounding arithmetic right shift: divides by 2^shift, rounding halves away from zero.
module kws_round_shift
  import kws_requant_pkg::*;
(
  input  logic signed [ACC_W-1:0] s_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  output logic signed [ACC_W-1:0] r_o
);

  logic [ACC_W-1:0]        mask;
  logic [ACC_W-1:0]        rem;
  logic [ACC_W-1:0]        thr;
  logic signed [ACC_W-1:0] floored;
  logic                    round_up;

  assign mask     = (ACC_W'(1) << shift_i) - ACC_W'(1);
  assign rem      = s_i & mask;
  // Negative values need a strictly larger remainder so ties round away from zero.
  assign thr      = (mask >> 1) + ACC_W'(s_i[ACC_W-1]);
  assign floored  = s_i >>> shift_i;
  assign round_up = rem > thr;
  assign r_o      = floored + ACC_W'(round_up);

endmodule

// File: rtl/kws_requant_pack.sv
// Three-stage int32 -> int8 requantizer followed by a 4-lane byte packer with
// ready/valid on both sides; one global advance enable stalls everything together.
module kws_requant_pack
  import kws_requant_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W-1:0]     in_acc,
  input  logic                 in_last,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ACC_W-1:0]     cfg_mult,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic [ACC_W-1:0]     cfg_offset,
  input  logic [LANE_W-1:0]    cfg_act_min,
  input  logic [LANE_W-1:0]    cfg_act_max,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [LANES-1:0]     out_keep
);

  localparam logic signed [63:0] NUDGE_POS  = 64'sh0000_0000_4000_0000;
  localparam logic signed [63:0] NUDGE_NEG  = 64'shFFFF_FFFF_C000_0001;
  localparam logic signed [63:0] TRUNC_BIAS = 64'sh0000_0000_7FFF_FFFF;

  logic         advance;
  requant_cfg_t cfg_q, cfg_in;

  logic                    s1_valid_q, s1_last_q, s1_sat_q, s1_sat_d;
  logic signed [63:0]      s1_prod_q, s1_prod_d;
  logic [SHIFT_W-1:0]      s1_shift_q;
  clamp_cfg_t              s1_clamp_q;

  logic                    s2_valid_q, s2_last_q;
  logic signed [ACC_W-1:0] s2_r_q, s2_r_d;
  clamp_cfg_t              s2_clamp_q;

  logic                    s3_valid_q, s3_last_q;
  logic [LANE_W-1:0]       s3_v_q, s3_v_d;

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][LANE_W-1:0]  lanes_q, lanes_d, lanes_w;
  logic [LANES-1:0]              keep_acc_q, keep_acc_d, keep_w, lane_hit;
  logic                          out_valid_q, out_valid_d;
  logic [OUT_W-1:0]              out_data_q, out_data_d;
  logic [LANES-1:0]              out_keep_q, out_keep_d;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign cfg_ready = ~(s1_valid_q | s2_valid_q | s3_valid_q | out_valid_q) & (cnt_q == '0);

  assign cfg_in = '{
    mult:  cfg_mult,
    shift: cfg_shift,
    clamp: '{offset: cfg_offset, act_min: cfg_act_min, act_max: cfg_act_max}
  };

  // Stage 1: full-precision product plus the one input pair whose product overflows Q31.
  logic signed [63:0] acc64, mult64;
  assign acc64     = {{32{in_acc[ACC_W-1]}}, in_acc};
  assign mult64    = {{32{cfg_q.mult[ACC_W-1]}}, cfg_q.mult};
  assign s1_prod_d = acc64 * mult64;
  assign s1_sat_d  = (in_acc == ACC_MIN_BITS) && (cfg_q.mult == ACC_MIN_BITS);

  // Stage 2: round-to-nearest Q31 high multiply, then the rounding shift.
  logic signed [63:0]      nudged, trunc_adj;
  logic signed [ACC_W-1:0] s_val;
  logic                    unused_trunc_bits;
  assign nudged    = s1_prod_q + (s1_prod_q[63] ? NUDGE_NEG : NUDGE_POS);
  assign trunc_adj = nudged + (nudged[63] ? TRUNC_BIAS : 64'sd0);
  assign s_val     = s1_sat_q ? 32'sh7FFF_FFFF : trunc_adj[62:31];
  assign unused_trunc_bits = ^{trunc_adj[63], trunc_adj[30:0]};

  kws_round_shift u_round_shift (
    .s_i     (s_val),
    .shift_i (s1_shift_q),
    .r_o     (s2_r_d)
  );

  // Stage 3: widened offset add, so the clamp sees the true sum.
  logic signed [ACC_W:0] sum, lo, hi;
  assign sum = {s2_r_q[ACC_W-1], s2_r_q} + {s2_clamp_q.offset[ACC_W-1], s2_clamp_q.offset};
  assign lo  = {{(ACC_W+1-LANE_W){s2_clamp_q.act_min[LANE_W-1]}}, s2_clamp_q.act_min};
  assign hi  = {{(ACC_W+1-LANE_W){s2_clamp_q.act_max[LANE_W-1]}}, s2_clamp_q.act_max};
  assign s3_v_d = (sum < lo) ? lo[LANE_W-1:0] :
                  (sum > hi) ? hi[LANE_W-1:0] : sum[LANE_W-1:0];

  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_hit[gi] = s3_valid_q && (cnt_q == CNT_W'(gi));
    assign lanes_w[gi]  = lane_hit[gi] ? s3_v_q : lanes_q[gi];
  end
  assign keep_w = keep_acc_q | lane_hit;

  always_comb begin
    cnt_d       = cnt_q;
    lanes_d     = lanes_q;
    keep_acc_d  = keep_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    if (advance) begin
      out_valid_d = 1'b0;
      if (s3_valid_q) begin
        if (cnt_q == CNT_W'(LANES-1) || s3_last_q) begin
          out_valid_d = 1'b1;
          out_data_d  = lanes_w;
          out_keep_d  = keep_w;
          cnt_d       = '0;
          lanes_d     = '0;
          keep_acc_d  = '0;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          lanes_d    = lanes_w;
          keep_acc_d = keep_w;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= RST_CFG;
    end else if (cfg_valid && cfg_ready) begin
      cfg_q <= cfg_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_prod_q   <= '0;
      s1_shift_q  <= '0;
      s1_clamp_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_r_q      <= '0;
      s2_clamp_q  <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_v_q      <= '0;
      cnt_q       <= '0;
      lanes_q     <= '0;
      keep_acc_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_last_q   <= in_last;
      s1_sat_q    <= s1_sat_d;
      s1_prod_q   <= s1_prod_d;
      s1_shift_q  <= cfg_q.shift;
      s1_clamp_q  <= cfg_q.clamp;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_r_q      <= s2_r_d;
      s2_clamp_q  <= s1_clamp_q;
      s3_valid_q  <= s2_valid_q;
      s3_last_q   <= s2_last_q;
      s3_v_q      <= s3_v_d;
      cnt_q       <= cnt_d;
      lanes_q     <= lanes_d;
      keep_acc_q  <= keep_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

endmodule
